// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: ID/EX, EX/MEM, MEM/WB control registers with load-use/branch hazard and forwarding control
//   clk, rst (async active-low)
//   *D inputs: decode-stage control bundle and register indices; ZeroE: ALU zero flag of EX
//   *E/*M/*W outputs: registered stage control; PCSrcE, StallF/D, FlushD/E, ForwardAE/BE: combinational hazard control
//   BubbleCnt: saturating count of cycles with FlushE asserted
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             ResultSrcD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             ZeroE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             ResultSrcE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic [2:0]       ALUControlE,
  output logic [4:0]       RdE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             ResultSrcM,
  output logic [4:0]       RdM,
  output logic             RegWriteW,
  output logic             ResultSrcW,
  output logic [4:0]       RdW,
  output logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] BubbleCnt
);
  logic [4:0] rs1_e, rs2_e;
  logic       lw_stall;
  assign lw_stall  = ResultSrcE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  assign PCSrcE    = BranchE & ZeroE;
  // a taken branch kills the stalled instruction in D, so the flush wins over the stall
  assign StallF    = lw_stall & ~PCSrcE;
  assign StallD    = lw_stall & ~PCSrcE;
  assign FlushD    = PCSrcE;
  assign FlushE    = lw_stall | PCSrcE;
  // MEM result is younger than WB, so it takes priority
  assign ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == rs1_e) ? 2'b10 :
                     (RegWriteW && RdW != 5'd0 && RdW == rs1_e) ? 2'b01 : 2'b00;
  assign ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == rs2_e) ? 2'b10 :
                     (RegWriteW && RdW != 5'd0 && RdW == rs2_e) ? 2'b01 : 2'b00;
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      {RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, ALUControlE, RdE, rs1_e, rs2_e} <= '0;
    else if (FlushE)
      {RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, ALUControlE, RdE, rs1_e, rs2_e} <= '0;
    else
      {RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, ALUControlE, RdE, rs1_e, rs2_e} <=
        {RegWriteD, MemWriteD, ResultSrcD, BranchD, ALUSrcD, ALUControlD, RdD, Rs1D, Rs2D};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {RegWriteM, MemWriteM, ResultSrcM, RdM} <= '0;
      {RegWriteW, ResultSrcW, RdW} <= '0;
    end else begin
      {RegWriteM, MemWriteM, ResultSrcM, RdM} <= {RegWriteE, MemWriteE, ResultSrcE, RdE};
      {RegWriteW, ResultSrcW, RdW} <= {RegWriteM, ResultSrcM, RdM};
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      BubbleCnt <= '0;
    else if (FlushE && BubbleCnt != '1)
      BubbleCnt <= BubbleCnt + CNT_W'(1);
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for the hazard controller, plus a CNT_W=2 instance for saturation
module tb_pipeline_hazard_ctrl;
  typedef struct packed {
    logic       rw;
    logic       mw;
    logic       rs;
    logic       br;
    logic       as;
    logic [2:0] alu;
    logic [4:0] rd;
  } ctl_t;
  logic clk = 0, rst = 0, zero = 0, sb_en = 0;
  ctl_t d = '0;
  logic [4:0] rs1 = '0, rs2 = '0;
  logic RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, RegWriteM, MemWriteM, ResultSrcM;
  logic RegWriteW, ResultSrcW, PCSrcE, StallF, StallD, FlushD, FlushE;
  logic [2:0] ALUControlE;
  logic [4:0] RdE, RdM, RdW;
  logic [1:0] ForwardAE, ForwardBE, bub2;
  logic [15:0] BubbleCnt, exp_bub;
  logic [1:0] exp_bub2;
  logic [36:0] u2;
  logic [12:0] e_bus;
  logic [7:0] m_bus;
  logic [6:0] w_bus;
  logic [8:0] comb;
  ctl_t qe[$], qm[$], qw[$];
  ctl_t sb_e, sb_m, sb_w;
  int compared = 0, mismatched = 0;
  assign e_bus = {RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, ALUControlE, RdE};
  assign m_bus = {RegWriteM, MemWriteM, ResultSrcM, RdM};
  assign w_bus = {RegWriteW, ResultSrcW, RdW};
  assign comb  = {PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
  always #5 clk = ~clk;
  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .RegWriteD(d.rw), .MemWriteD(d.mw), .ResultSrcD(d.rs), .BranchD(d.br), .ALUSrcD(d.as),
    .ALUControlD(d.alu), .Rs1D(rs1), .Rs2D(rs2), .RdD(d.rd), .ZeroE(zero),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .RdE(RdE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .BubbleCnt(BubbleCnt)
  );
  pipeline_hazard_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .RegWriteD(d.rw), .MemWriteD(d.mw), .ResultSrcD(d.rs), .BranchD(d.br), .ALUSrcD(d.as),
    .ALUControlD(d.alu), .Rs1D(rs1), .Rs2D(rs2), .RdD(d.rd), .ZeroE(zero),
    .RegWriteE(u2[12]), .MemWriteE(u2[11]), .ResultSrcE(u2[10]), .BranchE(u2[9]),
    .ALUSrcE(u2[8]), .ALUControlE(u2[7:5]), .RdE(u2[4:0]),
    .RegWriteM(u2[13]), .MemWriteM(u2[14]), .ResultSrcM(u2[15]), .RdM(u2[20:16]),
    .RegWriteW(u2[21]), .ResultSrcW(u2[22]), .RdW(u2[27:23]),
    .PCSrcE(u2[28]), .StallF(u2[29]), .StallD(u2[30]), .FlushD(u2[31]), .FlushE(u2[32]),
    .ForwardAE(u2[34:33]), .ForwardBE(u2[36:35]), .BubbleCnt(bub2)
  );
  function automatic ctl_t mk(input logic rw, mw, rs, br, as, input logic [2:0] alu, input logic [4:0] rd);
    return {rw, mw, rs, br, as, alu, rd};
  endfunction
  function automatic ctl_t lw(input logic [4:0] rd);  return mk(1, 0, 1, 0, 1, 3'd0, rd); endfunction
  function automatic ctl_t add(input logic [4:0] rd); return mk(1, 0, 0, 0, 0, 3'd0, rd); endfunction
  function automatic ctl_t sub(input logic [4:0] rd); return mk(1, 0, 0, 0, 0, 3'd1, rd); endfunction
  function automatic ctl_t beq();                     return mk(0, 0, 0, 1, 0, 3'd1, 5'd0); endfunction
  function automatic ctl_t nop();                     return '0; endfunction
  // scoreboard: each clock pops the expected E bundle and shifts it down the M/W queues
  always @(posedge clk) if (sb_en) begin
    #1;
    if (qe.size() == 0) begin
      compared++; mismatched++;
      $display("FAIL sb_underflow: no expected entry at %0t", $time);
    end else begin
      sb_e = qe.pop_front();
      sb_m = qm.pop_front();
      sb_w = qw.pop_front();
      compared++;
      if (e_bus !== sb_e) begin mismatched++; $display("FAIL e_stage got %h want %h at %0t", e_bus, sb_e, $time); end
      compared++;
      if (m_bus !== {sb_m.rw, sb_m.mw, sb_m.rs, sb_m.rd}) begin
        mismatched++; $display("FAIL m_stage got %h want %h at %0t", m_bus, {sb_m.rw, sb_m.mw, sb_m.rs, sb_m.rd}, $time);
      end
      compared++;
      if (w_bus !== {sb_w.rw, sb_w.rs, sb_w.rd}) begin
        mismatched++; $display("FAIL w_stage got %h want %h at %0t", w_bus, {sb_w.rw, sb_w.rs, sb_w.rd}, $time);
      end
      compared++;
      if (BubbleCnt !== exp_bub) begin mismatched++; $display("FAIL bubble_cnt got %0d want %0d at %0t", BubbleCnt, exp_bub, $time); end
      compared++;
      if (bub2 !== exp_bub2) begin mismatched++; $display("FAIL bubble_cnt2 got %0d want %0d at %0t", bub2, exp_bub2, $time); end
      compared++;
      if (u2[12:0] !== sb_e) begin mismatched++; $display("FAIL e_stage2 got %h want %h at %0t", u2[12:0], sb_e, $time); end
      qm.push_back(sb_e);
      qw.push_back(sb_m);
    end
  end
  task automatic sb_init();
    qe.delete(); qm.delete(); qw.delete();
    qm.push_back(nop());
    qw.push_back(nop());
    exp_bub = '0;
    exp_bub2 = '0;
  endtask
  task automatic do_reset();
    sb_en = 0;
    rst = 0;
    d = nop(); rs1 = '0; rs2 = '0; zero = 0;
    @(negedge clk);
    @(negedge clk);
    sb_init();
    rst = 1;
    sb_en = 1;
  endtask
  task automatic drive(input ctl_t nd, input logic [4:0] r1, r2, input logic z);
    d = nd; rs1 = r1; rs2 = r2; zero = z;
    #1;
  endtask
  task automatic tick(input logic fl);
    qe.push_back(fl ? nop() : d);
    if (fl) begin
      exp_bub  = (exp_bub == 16'hffff) ? exp_bub : exp_bub + 16'd1;
      exp_bub2 = (exp_bub2 == 2'd3) ? exp_bub2 : exp_bub2 + 2'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    sb_en = 0;
    rst = 0;
    d = add(5'd9); rs1 = 5'd9; rs2 = 5'd9; zero = 1;
    @(negedge clk);
    @(negedge clk);
    compared++; if (e_bus !== '0) begin mismatched++; $display("FAIL rst_e got %h want 0", e_bus); end
    compared++; if (m_bus !== '0) begin mismatched++; $display("FAIL rst_m got %h want 0", m_bus); end
    compared++; if (w_bus !== '0) begin mismatched++; $display("FAIL rst_w got %h want 0", w_bus); end
    compared++; if (BubbleCnt !== '0) begin mismatched++; $display("FAIL rst_cnt got %0d want 0", BubbleCnt); end
    compared++; if (comb !== '0) begin mismatched++; $display("FAIL rst_comb got %b want 0", comb); end
    sb_init();
    rst = 1;
    sb_en = 1;
    #1;
    compared++; if (e_bus !== '0) begin mismatched++; $display("FAIL rel_e got %h want 0", e_bus); end
    tick(0);
    compared++; if (RdE !== 5'd9) begin mismatched++; $display("FAIL rel_rde got %0d want 9", RdE); end
  endtask
  task automatic test_load_use();
    do_reset();
    drive(lw(5'd5), 5'd1, 5'd0, 0);
    compared++; if (comb !== 9'b0) begin mismatched++; $display("FAIL lu_issue got %b want %b", comb, 9'b0); end
    tick(0);
    drive(add(5'd6), 5'd5, 5'd2, 0);
    compared++; if (comb !== 9'b0_1_1_0_1_00_00) begin mismatched++; $display("FAIL lu_stall got %b want %b", comb, 9'b0_1_1_0_1_00_00); end
    tick(1);
    compared++; if (BubbleCnt !== 16'd1) begin mismatched++; $display("FAIL lu_cnt got %0d want 1", BubbleCnt); end
    compared++; if (comb !== 9'b0) begin mismatched++; $display("FAIL lu_release got %b want %b", comb, 9'b0); end
    tick(0);
    drive(nop(), 5'd0, 5'd0, 0);
    compared++; if (comb !== 9'b0_0_0_0_0_01_00) begin mismatched++; $display("FAIL lu_fwd got %b want %b", comb, 9'b0_0_0_0_0_01_00); end
    tick(0);
  endtask
  task automatic test_ex_forward();
    do_reset();
    drive(add(5'd3), 5'd1, 5'd2, 0);
    tick(0);
    drive(sub(5'd4), 5'd1, 5'd3, 0);
    compared++; if (comb !== 9'b0) begin mismatched++; $display("FAIL exf_nostall got %b want %b", comb, 9'b0); end
    tick(0);
    drive(nop(), 5'd0, 5'd0, 0);
    compared++; if (comb !== 9'b0_0_0_0_0_00_10) begin mismatched++; $display("FAIL exf_fwdb got %b want %b", comb, 9'b0_0_0_0_0_00_10); end
    tick(0);
  endtask
  task automatic test_priority();
    do_reset();
    drive(add(5'd7), 5'd1, 5'd2, 0); tick(0);
    drive(add(5'd7), 5'd1, 5'd2, 0); tick(0);
    drive(add(5'd8), 5'd7, 5'd0, 0); tick(0);
    drive(nop(), 5'd0, 5'd0, 0);
    compared++; if (comb !== 9'b0_0_0_0_0_10_00) begin mismatched++; $display("FAIL pri_mem got %b want %b", comb, 9'b0_0_0_0_0_10_00); end
    tick(0);
    do_reset();
    drive(add(5'd0), 5'd1, 5'd2, 0); tick(0);
    drive(add(5'd0), 5'd1, 5'd2, 0); tick(0);
    drive(add(5'd8), 5'd0, 5'd0, 0); tick(0);
    drive(nop(), 5'd0, 5'd0, 0);
    compared++; if (comb !== 9'b0) begin mismatched++; $display("FAIL pri_x0 got %b want %b", comb, 9'b0); end
    tick(0);
    drive(lw(5'd0), 5'd0, 5'd0, 0); tick(0);
    drive(add(5'd1), 5'd0, 5'd0, 0);
    compared++; if (comb !== 9'b0) begin mismatched++; $display("FAIL lw_x0 got %b want %b", comb, 9'b0); end
    tick(0);
  endtask
  task automatic test_branch();
    do_reset();
    drive(beq(), 5'd1, 5'd2, 0); tick(0);
    drive(add(5'd9), 5'd3, 5'd4, 1);
    compared++; if (comb !== 9'b1_0_0_1_1_00_00) begin mismatched++; $display("FAIL br_taken got %b want %b", comb, 9'b1_0_0_1_1_00_00); end
    tick(1);
    drive(add(5'd9), 5'd3, 5'd4, 1);
    compared++; if (comb !== 9'b0) begin mismatched++; $display("FAIL br_once got %b want %b", comb, 9'b0); end
    tick(0);
    drive(beq(), 5'd1, 5'd2, 0); tick(0);
    drive(add(5'd10), 5'd3, 5'd4, 0);
    compared++; if (comb !== 9'b0) begin mismatched++; $display("FAIL br_nottaken got %b want %b", comb, 9'b0); end
    tick(0);
    drive(nop(), 5'd0, 5'd0, 0); tick(0);
    compared++; if (BubbleCnt !== 16'd1) begin mismatched++; $display("FAIL br_cnt got %0d want 1", BubbleCnt); end
  endtask
  task automatic test_branch_load_use();
    do_reset();
    // a bundle that is both a branch and a load exercises both hazards at once
    drive(mk(0, 0, 1, 1, 0, 3'd1, 5'd5), 5'd1, 5'd2, 0); tick(0);
    drive(add(5'd6), 5'd5, 5'd0, 1);
    compared++; if (comb !== 9'b1_0_0_1_1_00_00) begin mismatched++; $display("FAIL brlu got %b want %b", comb, 9'b1_0_0_1_1_00_00); end
    tick(1);
    drive(add(5'd6), 5'd5, 5'd0, 1);
    compared++; if (comb !== 9'b0) begin mismatched++; $display("FAIL brlu_after got %b want %b", comb, 9'b0); end
    tick(0);
  endtask
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(lw(5'd5), 5'd0, 5'd0, 0); tick(0);
      drive(add(5'd6), 5'd5, 5'd0, 0);
      compared++; if (comb !== 9'b0_1_1_0_1_00_00) begin mismatched++; $display("FAIL sat_stall%0d got %b want %b", i, comb, 9'b0_1_1_0_1_00_00); end
      tick(1);
    end
    compared++; if (BubbleCnt !== 16'd5) begin mismatched++; $display("FAIL sat_cnt16 got %0d want 5", BubbleCnt); end
    compared++; if (bub2 !== 2'd3) begin mismatched++; $display("FAIL sat_cnt2 got %0d want 3", bub2); end
  endtask
  task automatic test_reset_mid_stall();
    do_reset();
    drive(lw(5'd5), 5'd1, 5'd0, 0); tick(0);
    drive(add(5'd6), 5'd5, 5'd2, 0);
    compared++; if (comb !== 9'b0_1_1_0_1_00_00) begin mismatched++; $display("FAIL rm_pre got %b want %b", comb, 9'b0_1_1_0_1_00_00); end
    #2;
    sb_en = 0;
    rst = 0;
    #1;
    compared++; if (comb !== 9'b0) begin mismatched++; $display("FAIL rm_comb got %b want %b", comb, 9'b0); end
    compared++; if (e_bus !== '0) begin mismatched++; $display("FAIL rm_e got %h want 0", e_bus); end
    @(negedge clk);
    sb_init();
    rst = 1;
    sb_en = 1;
    drive(add(5'd6), 5'd5, 5'd2, 0);
    compared++; if (comb !== 9'b0) begin mismatched++; $display("FAIL rm_release got %b want %b", comb, 9'b0); end
    tick(0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_load_use();
    test_ex_forward();
    test_priority();
    test_branch();
    test_branch_load_use();
    test_saturation();
    test_reset_mid_stall();
    sb_en = 0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
